// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle chunked ripple adder/subtractor
//
// Adds (or subtracts) two WIDTH-bit operands CHUNK bits per clock, least
// significant chunk first, carrying between chunks in a register.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present           in_ready   accepting (state IDLE)
//   A, B       WIDTH-bit operands         Cin        carry-in
//   Sub        0: A+B+Cin, 1: A-B-Cin
//   S          result register            Cout       carry out (1 = no borrow in Sub)
//   Ovf        two's-complement overflow
//   out_valid  result valid (state DONE)  out_ready  consumer accepts result

module serial_chunk_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

   generate
      if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("serial_chunk_adder: WIDTH must be >= 1 and a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [31:0]      base;
   logic [CHUNK:0]   chunk_sum;
   logic             last_chunk;

   assign base       = 32'(k_q) * 32'(CHUNK);
   assign last_chunk = (k_q == KW'(NCH - 1));
   assign chunk_sum  = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                     + {{CHUNK{1'b0}}, carry_q};

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtraction is A + ~B + ~Cin, so invert B and Cin up front.
               a_d     = A;
               b_d     = Sub ? ~B : B;
               carry_d = Cin ^ Sub;
               k_d     = '0;
               s_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
            carry_d            = chunk_sum[CHUNK];
            if (last_chunk) begin
               // The top sum bit of the last chunk is result bit WIDTH-1.
               cout_d  = chunk_sum[CHUNK];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign S         = s_q;
   assign Cout      = cout_q;
   assign Ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - randomized self-checking bench for serial_chunk_adder
//
// Main instance 64/8 with a scoreboard, plus swept instances 16/16, 8/1, 12/4.

module tb_serial_chunk_adder;

   localparam int W = 64;
   localparam int C = 8;
   localparam int N = W / C;

   logic         clk = 1'b0;
   logic         rst_n, rst_sw_n;
   logic         in_valid, in_ready, Cin, Sub, Cout, Ovf, out_valid, out_ready;
   logic [W-1:0] A, B, S;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ready_mode = 1;
   int sw_done = 0;

   typedef struct {
      logic [63:0] s;
      logic        cout;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .Sub(Sub), .S(S), .Cout(Cout), .Ovf(Ovf),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit operands.
   function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub,
                                 output logic [63:0] s, output logic cout, output logic ovf);
      logic [63:0]        m;
      logic [67:0]        ua, ub, ur, uc;
      logic signed [67:0] sa, sb, sc, r, lim;
      m   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      ua  = {4'd0, a & m};
      ub  = {4'd0, b & m};
      uc  = 68'(cin);
      ur  = sub ? (ua - ub - uc) : (ua + ub + uc);
      s   = ur[63:0] & m;
      cout = sub ? (ua >= ub + uc) : ((ur >> w) != 68'd0);
      sa  = $signed(ua << (68 - w));
      sa  = sa >>> (68 - w);
      sb  = $signed(ub << (68 - w));
      sb  = sb >>> (68 - w);
      sc  = $signed(uc);
      r   = sub ? (sa - sb - sc) : (sa + sb + sc);
      lim = 68'sd1 <<< (w - 1);
      ovf = (r >= lim) || (r < -lim);
   endfunction

   // Consumer: 0 = hold low, 1 = always ready, 2 = random.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = (ready_mode == 1) ? 1'b1 :
                     (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // Single compare process for the main instance.
   initial begin
      logic prev_ov;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            check("in_ready_in_done", 64'(in_ready), 64'd0);
            if (q.size() == 0) begin
               check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               check("S", S, q[0].s);
               check("Cout", 64'(Cout), 64'(q[0].cout));
               check("Ovf", 64'(Ovf), 64'(q[0].ovf));
               if (!prev_ov) check("latency", 64'(cyc - q[0].acc), 64'(N));
               if (out_ready === 1'b1) void'(q.pop_front());
            end
         end
         prev_ov = out_valid;
      end
   end

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
      exp_t e;
      int   n;
      @(posedge clk);
      #2;
      A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("accept_timeout", 64'(in_ready), 64'd1);
      model(W, a, b, cin, sub, e.s, e.cout, e.ovf);
      e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      A = {$urandom, $urandom}; B = {$urandom, $urandom};
      Cin = 1'($urandom); Sub = 1'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0: pick = 64'd0;
         1: pick = '1;
         2: pick = 64'h8000_0000_0000_0000;
         3: pick = 64'h7FFF_FFFF_FFFF_FFFF;
         default: pick = {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [63:0] ps;
      logic        pc, po;
      int          n;

      rst_n = 1'b0; rst_sw_n = 1'b0; in_valid = 1'b0;
      A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
      #1;
      check("rst_S", S, 64'd0);
      check("rst_Cout", 64'(Cout), 64'd0);
      check("rst_Ovf", 64'(Ovf), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1; rst_sw_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_out_valid", 64'(out_valid), 64'd0);

      // Hand-computed pins for the reference model.
      model(64, '1, 64'd0, 1'b1, 1'b0, ps, pc, po);
      check("pin_carry_S", ps, 64'd0); check("pin_carry_Cout", 64'(pc), 64'd1);
      check("pin_carry_Ovf", 64'(po), 64'd0);
      model(64, 64'd5, 64'd7, 1'b0, 1'b1, ps, pc, po);
      check("pin_borrow_S", ps, 64'hFFFF_FFFF_FFFF_FFFE); check("pin_borrow_Cout", 64'(pc), 64'd0);
      check("pin_borrow_Ovf", 64'(po), 64'd0);
      model(64, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, ps, pc, po);
      check("pin_subovf_S", ps, 64'h7FFF_FFFF_FFFF_FFFF); check("pin_subovf_Cout", 64'(pc), 64'd1);
      check("pin_subovf_Ovf", 64'(po), 64'd1);
      model(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, ps, pc, po);
      check("pin_addovf_S", ps, 64'hFFFF_FFFF_FFFF_FFFE); check("pin_addovf_Cout", 64'(pc), 64'd0);
      check("pin_addovf_Ovf", 64'(po), 64'd1);
      model(12, 64'hFFF, 64'h001, 1'b0, 1'b0, ps, pc, po);
      check("pin_w12_S", ps, 64'd0); check("pin_w12_Cout", 64'(pc), 64'd1);

      // Directed cases through the DUT.
      send('1, 64'd0, 1'b1, 1'b0);
      send(64'd5, 64'd7, 1'b0, 1'b1);
      send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      drain();

      // Backpressure with noisy inputs during RUN and DONE.
      @(negedge clk);
      ready_mode = 0;
      send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bp_out_valid_rise", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid_held", 64'(out_valid), 64'd1);
         check("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      ready_mode = 1;
      @(negedge clk);
      check("bp_in_ready_at_release", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("bp_in_ready_after", 64'(in_ready), 64'd1);
      check("bp_out_valid_dropped", 64'(out_valid), 64'd0);
      drain();

      // Abort mid-operation at chunk index 3.
      send(pick(), pick(), 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      check("abort_S", S, 64'd0);
      check("abort_Cout", 64'(Cout), 64'd0);
      check("abort_Ovf", 64'(Ovf), 64'd0);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < N + 4; i++) begin
         @(negedge clk);
         check("abort_no_valid", 64'(out_valid), 64'd0);
      end
      send(64'd1, 64'd2, 1'b0, 1'b0);
      drain();

      // Randomized traffic with random consumer stalls.
      @(negedge clk);
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         send(pick(), pick(), 1'($urandom), 1'($urandom));
      end
      drain();

      n = 0;
      while (sw_done < 3 && n < 40000) begin
         @(negedge clk);
         n++;
      end
      check("sweep_done", 64'(sw_done), 64'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Parameter sweep: one operation in flight per instance, checked directly.
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int SWID = (g == 0) ? 16 : (g == 1) ? 8 : 12;
      localparam int SCH  = (g == 0) ? 16 : (g == 1) ? 1 : 4;
      localparam int SN   = SWID / SCH;

      logic [SWID-1:0] a, b, s;
      logic            ci, sb, co, ov, iv, ir, ovl, ordy;

      serial_chunk_adder #(.WIDTH(SWID), .CHUNK(SCH)) u_dut (
         .clk(clk), .rst_n(rst_sw_n), .in_valid(iv), .in_ready(ir),
         .A(a), .B(b), .Cin(ci), .Sub(sb), .S(s), .Cout(co), .Ovf(ov),
         .out_valid(ovl), .out_ready(ordy)
      );

      initial begin
         logic [63:0] es;
         logic        eco, eov;
         int          acc, n;
         iv = 1'b0; ordy = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0;
         wait (rst_sw_n === 1'b1);
         for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #2;
            a = SWID'($urandom); b = SWID'($urandom);
            ci = 1'($urandom); sb = 1'($urandom); iv = 1'b1;
            n = 0;
            @(negedge clk);
            while (ir !== 1'b1 && n < 50) begin
               @(negedge clk);
               n++;
            end
            model(SWID, 64'(a), 64'(b), ci, sb, es, eco, eov);
            acc = cyc + 1;
            @(posedge clk);
            #2;
            iv = 1'b0; a = SWID'($urandom); b = SWID'($urandom);
            n = 0;
            @(negedge clk);
            while (ovl !== 1'b1 && n < 100) begin
               @(negedge clk);
               n++;
            end
            check($sformatf("sweep%0d_latency", g), 64'(cyc - acc), 64'(SN));
            check($sformatf("sweep%0d_S", g), 64'(s), es);
            check($sformatf("sweep%0d_Cout", g), 64'(co), 64'(eco));
            check($sformatf("sweep%0d_Ovf", g), 64'(ov), 64'(eov));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(posedge clk);
            #2;
            ordy = 1'b1;
            @(posedge clk);
            #2;
            ordy = 1'b0;
         end
         sw_done++;
      end
   end

endmodule

// File: doc/serial_chunk_adder.md
# serial_chunk_adder

Multi-cycle, parametrised ripple adder/subtractor. It accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake and adds them CHUNK bits per clock, least-significant chunk first, holding the inter-chunk carry in a register. It returns sum, carry-out and signed overflow over a second handshake. It is the sequential, width-generalised successor of the team's 1-bit full-adder cell. It is used where a full-width combinational carry chain does not meet timing or area.

## Interface
- WIDTH, 64: operand and result width in bits; must be ≥ 1.
- CHUNK, 8: bits added per clock; WIDTH % CHUNK must be 0, otherwise elaboration fails.
- Derived NCH = WIDTH / CHUNK: number of chunk cycles per operation.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; combinational, equals (state == IDLE).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in.
- Sub  in  1  mode: 0 = A+B+Cin; 1 = A−B−Cin (A + ~B + ~Cin).
- S  out  WIDTH  result register.
- Cout  out  1  final carry out of bit WIDTH−1; in subtract mode, 1 = no borrow.
- Ovf  out  1  two's-complement overflow of the WIDTH-bit result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

## Operation
- FSM states are IDLE, RUN and DONE. The chunk index k counts 0..NCH−1.
- **IDLE**
  - in_ready = 1.
  - On in_valid = 1, latch: a_r = A; b_r = Sub ? ~B : B; carry_r = Cin ^ Sub; k = 0; S = 0.
  - Then go to RUN.
- **RUN**
  - Each cycle compute {c, sum} = a_r[k*CHUNK +: CHUNK] + b_r[k*CHUNK +: CHUNK] + carry_r, with CHUNK+1-bit arithmetic.
  - Write sum into S[k*CHUNK +: CHUNK] and set carry_r = c.
  - On k = NCH−1:
    - Cout = c.
    - Ovf = (a_r[MSB] == b_r[MSB]) & (sum[CHUNK−1] != a_r[MSB]).
    - out_valid = 1; go to DONE.
  - Otherwise k = k+1.
- **DONE**
  - out_valid = 1; S, Cout and Ovf are held stable.
  - When out_ready = 1: out_valid = 0; go to IDLE.
- in_valid is ignored outside IDLE, and operands are sampled only at acceptance. A, B, Cin and Sub may change freely afterwards.
- S, Cout and Ovf hold their last values in IDLE. At the next acceptance, S clears to 0; Cout and Ovf are updated only at the last chunk.
- NCH = 1 (CHUNK = WIDTH) is legal: RUN lasts exactly one cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE; k = 0.
  - S = 0, Cout = 0, Ovf = 0, out_valid = 0, carry_r = 0.
  - in_ready reads 1 from the first cycle after reset.
- Reset mid-operation aborts immediately. No out_valid is produced for the aborted operand.
- Latency: accept at edge E0. Chunk j is written at edge E0+1+j. out_valid rises at edge E0+NCH.
- out_valid stays high for as many cycles as out_ready stays low. The result is not lost under backpressure.
- out_ready already high in the first DONE cycle → IDLE at the next edge, and in_ready = 1 in the following cycle.
- Minimum period is NCH+2 cycles per operation (accept, NCH chunk cycles, DONE handoff): 10 cycles for 64/8.
- in_valid and out_ready are never combinationally coupled to each other.

## Test plan
- WIDTH=64, CHUNK=8, Sub=0: A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> S=0, Cout=1, Ovf=0. out_valid rises exactly 8 cycles after acceptance, and the carry ripples across all chunks.
- Sub=1, Cin=0: A=5, B=7 -> S=0xFFFF_FFFF_FFFF_FFFE, Cout=0 (borrow), Ovf=0. Second case: A=0x8000_0000_0000_0000, B=1 -> S=0x7FFF_FFFF_FFFF_FFFF, Ovf=1, Cout=1.
- Sub=0: A=B=0x7FFF_FFFF_FFFF_FFFF, Cin=0 -> S=0xFFFF_FFFF_FFFF_FFFE, Ovf=1, Cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid, S, Cout and Ovf are stable throughout. Changing A/B/in_valid during RUN and DONE has no effect, and in_ready=0 until the cycle after out_ready=1.
- Pull rst_n low at chunk k=3 -> all outputs 0 immediately and no out_valid afterwards. The next operation A=1, B=2 -> S=3.
- Parameter sweep (CHUNK=WIDTH=16; CHUNK=1, WIDTH=8; CHUNK=4, WIDTH=12): 1000 random vectors per configuration against A+B+Cin / A−B−Cin reference. Check latency = NCH, and that WIDTH=12, CHUNK=5 fails elaboration.
